// File: rtl/midi_transmit.sv
// midi_transmit: serialises a 1-3 byte MIDI message as 8N1 frames on midi_out
// Ports: clck/rst (async active-high); msg_valid/msg_ready handshake with
// status_byte, data1, data2, msg_len (0 = null message); midi_out serial line
// (idle high); busy while a message is in flight; byte_done pulses on the last
// clock of each stop bit.
// Optional: define MIDI_TX_RUNNING_STATUS_EN to skip a repeated channel status.
module midi_transmit #(
  parameter int CLKS_PER_BIT    = 128,
  parameter int HALF_STOP_EXTRA = 0
) (
  input  logic       clck,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] status_byte,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [1:0] msg_len,
  output logic       midi_out,
  output logic       busy,
  output logic       byte_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(HALF_STOP_EXTRA > 0 ? HALF_STOP_EXTRA - 1 : 0);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n, len_r;
  logic [7:0] b0, b1, b2, cur;
  logic go, skip, mo_d;
  assign go = msg_valid && msg_ready && msg_len != 2'd0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic chan;
  assign chan = status_byte >= 8'h80 && status_byte <= 8'hEF;
  assign skip = chan && status_byte == last_status && msg_len >= 2'd2;
  always_ff @(posedge clck or posedge rst)
    if (rst) last_status <= 8'h00;
    else if (go) last_status <= chan ? status_byte : status_byte <= 8'hF7 && status_byte >= 8'hF0 ? 8'h00 : last_status;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clck or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      len_r     <= '0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      midi_out  <= 1'b1;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      midi_out  <= mo_d;
      msg_ready <= state_n == IDLE;
      busy      <= state_n != IDLE;
      if (go) begin
        b0    <= status_byte;
        b1    <= data1;
        b2    <= data2;
        len_r <= msg_len;
      end
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (go) begin
          state_n = START;
          byte_n  = skip ? 2'd1 : 2'd0;
        end
      end
      START:
        if (cnt == CNT_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = 3'd0;
        end
      DATA:
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          bit_n   = bit_idx + 3'd1;
          state_n = bit_idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (byte_idx == len_r - 2'd1) state_n = HALF_STOP_EXTRA > 0 ? GAP : IDLE;
          else begin
            state_n = START;
            byte_n  = byte_idx + 2'd1;
          end
        end
      GAP:
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  always_comb begin
    cur       = byte_n == 2'd0 ? b0 : byte_n == 2'd1 ? b1 & 8'h7F : b2 & 8'h7F;
    mo_d      = state_n == DATA ? cur[bit_n] : state_n != START;
    byte_done = state == STOP && cnt == CNT_LAST;
  end
endmodule

// File: tb/tb_midi_transmit.sv
// tb_midi_transmit: directed checks of midi_transmit framing, handshake and reset
module tb_midi_transmit;
  logic clck = 1'b0;
  logic rst = 1'b1;
  logic msg_valid = 1'b0;
  logic msg_ready;
  logic [7:0] status_byte = '0;
  logic [7:0] data1 = '0;
  logic [7:0] data2 = '0;
  logic [1:0] msg_len = '0;
  logic midi_out, busy, byte_done;
  int n_vec = 0;
  int n_bad = 0;
  int bd_cnt = 0;
  midi_transmit dut (
    .clck(clck), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .status_byte(status_byte), .data1(data1), .data2(data2), .msg_len(msg_len),
    .midi_out(midi_out), .busy(busy), .byte_done(byte_done)
  );
  always #5 clck = ~clck;
  always @(posedge clck) if (!rst && byte_done) bd_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " ready"}, msg_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " line"}, midi_out, 1);
  endtask
  task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] l);
    status_byte = s;
    data1 = d1;
    data2 = d2;
    msg_len = l;
    msg_valid = 1'b1;
    @(negedge clck);
    msg_valid = 1'b0;
    status_byte = 8'h00;
    data1 = 8'hFF;
    data2 = 8'hFF;
    msg_len = 2'd0;
    chk("latency line", midi_out, 0);
    chk("latency busy", busy, 1);
  endtask
  task automatic rx(input logic [7:0] exp, input string tag);
    logic [7:0] b;
    repeat (64) @(negedge clck);
    chk({tag, " start"}, midi_out, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (128) @(negedge clck);
      b[i] = midi_out;
    end
    chk({tag, " byte"}, b, exp);
    repeat (128) @(negedge clck);
    chk({tag, " stop"}, midi_out, 1);
    repeat (63) @(negedge clck);
    chk({tag, " byte_done"}, byte_done, 1);
    @(negedge clck);
  endtask
  initial begin
    int lows, bd0;
    repeat (3) @(negedge clck);
    chk("rst line", midi_out, 1);
    chk("rst ready", msg_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst byte_done", byte_done, 0);
    rst = 1'b0;
    @(negedge clck);
    idle_chk("post rst");
    bd0 = bd_cnt;
    send(8'h90, 8'h3C, 8'h64, 2'd3);
    chk("accept ready low", msg_ready, 0);
    rx(8'h90, "on0");
    rx(8'h3C, "on1");
    rx(8'h64, "on2");
    idle_chk("on end");
    chk("on byte_done count", bd_cnt - bd0, 3);
    status_byte = 8'hF8;
    msg_len = 2'd1;
    msg_valid = 1'b1;
    @(negedge clck);
    chk("rt line", midi_out, 0);
    status_byte = 8'hC5;
    data1 = 8'hBC;
    data2 = 8'h7E;
    msg_len = 2'd2;
    rx(8'hF8, "rt");
    idle_chk("rt end");
    @(negedge clck);
    msg_valid = 1'b0;
    chk("held start", midi_out, 0);
    rx(8'hC5, "pc0");
    rx(8'h3C, "pc1");
    idle_chk("pc end");
    status_byte = 8'hA0;
    msg_len = 2'd0;
    msg_valid = 1'b1;
    @(negedge clck);
    msg_valid = 1'b0;
    chk("null ready", msg_ready, 1);
    chk("null busy", busy, 0);
    lows = 0;
    repeat (200) begin
      @(negedge clck);
      if (!midi_out || busy || !msg_ready) lows++;
    end
    chk("null quiet", lows, 0);
    send(8'h80, 8'h3C, 8'h40, 2'd3);
    repeat (699) @(negedge clck);
    chk("pre rst line", midi_out, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst line", midi_out, 1);
    chk("async rst busy", busy, 0);
    chk("async rst ready", msg_ready, 0);
    repeat (3) @(negedge clck);
    rst = 1'b0;
    @(negedge clck);
    idle_chk("rst release");
    send(8'hB1, 8'h07, 8'h7F, 2'd3);
    rx(8'hB1, "cc0");
    rx(8'h07, "cc1");
    rx(8'h7F, "cc2");
    idle_chk("cc end");
    send(8'h90, 8'h3C, 8'h64, 2'd3);
    rx(8'h90, "rs a0");
    rx(8'h3C, "rs a1");
    rx(8'h64, "rs a2");
    idle_chk("rs a end");
    send(8'h90, 8'h40, 8'h64, 2'd3);
`ifndef MIDI_TX_RUNNING_STATUS_EN
    rx(8'h90, "rs b0");
`endif
    rx(8'h40, "rs b1");
    rx(8'h64, "rs b2");
    idle_chk("rs b end");
    send(8'hF2, 8'h10, 8'h20, 2'd3);
    rx(8'hF2, "sp0");
    rx(8'h10, "sp1");
    rx(8'h20, "sp2");
    idle_chk("sp end");
    send(8'h90, 8'h3C, 8'h64, 2'd3);
    rx(8'h90, "rs c0");
    rx(8'h3C, "rs c1");
    rx(8'h64, "rs c2");
    idle_chk("rs c end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/midi_transmit.md
Name: midi_transmit

Overview:
- Serialises one complete MIDI message (1–3 bytes) onto a MIDI OUT line as 31.25 kbaud 8N1 frames.
- It is the transmit-side counterpart of the MIDI receiver and uses the same bit timing: 128 clocks per bit at 4 MHz, which is 32 us.
- Sits between the note and control logic (message source) and the MIDI OUT pin driver.
- Accepts a message through a valid/ready handshake and sends its bytes back-to-back with no inter-byte gap.

Parameters:
- CLKS_PER_BIT, 128, clocks per serial bit. Must be ≥2.
- HALF_STOP_EXTRA, 0, extra idle-high clocks appended after the last stop bit of each message. Range 0..CLKS_PER_BIT.

Ports:
- clck, input, 1, system clock (4 MHz nominal).
- rst, input, 1, reset; asynchronous, active-high.
- msg_valid, input, 1, source has a message on status_byte/data1/data2/msg_len.
- msg_ready, output, 1, block can accept a message this cycle.
- status_byte, input, 8, first byte; bit7 expected 1.
- data1, input, 8, second byte; bit7 forced to 0 on transmit.
- data2, input, 8, third byte; bit7 forced to 0 on transmit.
- msg_len, input, 2, number of bytes to send: 1, 2 or 3. 0 means a null message.
- midi_out, output, 1, serial line; idle high.
- busy, output, 1, high from the accept cycle until the block returns to IDLE.
- byte_done, output, 1, one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values: midi_out=1, msg_ready=0 while rst is asserted, busy=0, byte_done=0. State=IDLE; bit and clock counters=0.
  - rst asserted mid-frame forces midi_out high immediately (asynchronous reset). The partial frame is abandoned and is not resumed.
- msg_ready is 1 only in IDLE when rst is low. It is registered, so it rises the cycle after rst deasserts.
- Accept occurs when msg_valid && msg_ready on a rising clck edge.
  - All inputs are latched at accept; later input changes have no effect.
  - msg_valid held with msg_ready low has no effect.
- msg_len=0 is a null message: the handshake completes, nothing is sent, busy stays 0, and msg_ready remains 1.
- States: IDLE, START, DATA, STOP, GAP.
  - IDLE → START on accept with msg_len≠0.
  - START: midi_out=0 for CLKS_PER_BIT clocks, then → DATA.
  - DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT clocks; bit index 0..7. After bit 7 → STOP.
  - STOP: midi_out=1 for CLKS_PER_BIT clocks. byte_done pulses on the last clock of STOP.
    - More bytes remaining → START, with the next start bit on the very next clock (no gap).
    - Otherwise → GAP if HALF_STOP_EXTRA>0, else IDLE.
  - GAP: midi_out=1 for HALF_STOP_EXTRA clocks, then → IDLE.
- Latency: the accept edge at cycle N drives midi_out low from cycle N+1. midi_out is a direct flop output (glitch-free).
- Frame timing: one byte takes 10×CLKS_PER_BIT clocks. A 3-byte message takes 30×CLKS_PER_BIT + HALF_STOP_EXTRA clocks from first start bit to msg_ready=1.
- Byte order on the line: status_byte, then data1, then data2. Bytes at index ≥ msg_len are not sent.
- Data bytes are sent with bit7 cleared. status_byte is sent unmodified, even if its bit7 is 0.
- Clock counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it is never free-running in IDLE.
- busy falls in the same cycle msg_ready rises.
- Back-to-back messages: a message accepted on the first IDLE cycle starts its start bit on the next clock. The minimum idle between messages is 1 clock plus HALF_STOP_EXTRA.

Optional Feature:
- Macro: MIDI_TX_RUNNING_STATUS_EN.
- Defined:
  - The block keeps last_status (reset 0x00).
  - For a channel message (status 0x80–0xEF) equal to last_status with msg_len≥2, the status byte is skipped and transmission starts with data1.
  - Any transmitted channel status updates last_status.
  - System common 0xF0–0xF7 clears last_status to 0x00.
  - Realtime 0xF8–0xFF leaves it unchanged.
- Undefined: the status byte is always sent; no last_status register exists.

Test Plan:
- Note-on 0x90,0x3C,0x64, msg_len=3, CLKS_PER_BIT=128 → midi_out low at accept+1. Byte 0 bits sample 0,0,0,0,1,0,0,1 at bit centres (+64 clocks), then stop high. Total 3840 clocks; 3 byte_done pulses 1280 clocks apart; msg_ready=1 at accept+3841.
- msg_len=1, status 0xF8 → single 1280-clock frame with bits 0,0,0,1,1,1,1,1. A message held valid during transmission is accepted only after return to IDLE.
- data1=0xBC with msg_len=2 → second frame carries 0x3C (bit7 cleared). msg_len=0 → no line activity, busy stays 0.
- rst asserted at clock 700 of a 3-byte message → midi_out=1 asynchronously, busy=0. After release, msg_ready=1 one clock later and the next message transmits cleanly.
- MIDI_TX_RUNNING_STATUS_EN: send 0x90,0x3C,0x64 then 0x90,0x40,0x64 → second message is 2 frames (2560 clocks). Then 0xF2,... then 0x90,... → status resent.
